// File: rtl/pipe_addsub.sv
// Pipelined add/subtract, WIDTH/CHUNK carry-chained stages, valid/ready both sides.
// Define PIPE_ADDSUB_SAT_EN for unsigned saturation of the final result.
module pipe_addsub #(
  parameter int WIDTH = 8,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / CHUNK;
  localparam int MSB    = WIDTH - 1;

  logic stall;
  logic adv;

  assign stall    = out_valid && !out_ready;
  assign adv      = !stall;
  assign in_ready = !stall;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             v_q;
    logic             vv;
    logic             cv;
    logic             subv;
    logic [WIDTH-1:0] av;
    logic [WIDTH-1:0] bv;
    logic [WIDTH-1:0] sv;
    logic [WIDTH-1:0] s_d;
    logic [CHUNK:0]   t;

    // b is inverted once at entry so every stage is a plain adder
    if (k == 0) begin : g_in
      assign vv   = in_valid;
      assign av   = a;
      assign bv   = b ^ {WIDTH{sub}};
      assign cv   = ci ^ sub;
      assign sv   = '0;
      assign subv = sub;
    end else begin : g_mid
      assign vv   = g_st[k-1].v_q;
      assign av   = g_st[k-1].g_reg.a_q;
      assign bv   = g_st[k-1].g_reg.b_q;
      assign cv   = g_st[k-1].g_reg.cy_q;
      assign sv   = g_st[k-1].g_reg.s_q;
      assign subv = g_st[k-1].g_reg.sub_q;
    end

    assign t = {1'b0, av[k*CHUNK +: CHUNK]}
             + {1'b0, bv[k*CHUNK +: CHUNK]}
             + {{CHUNK{1'b0}}, cv};

    always_comb begin
      s_d = sv;
      s_d[k*CHUNK +: CHUNK] = t[CHUNK-1:0];
    end

    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
      end else if (adv) begin
        v_q <= vv;
      end
    end

    if (k < STAGES - 1) begin : g_reg
      logic [WIDTH-1:0] a_q;
      logic [WIDTH-1:0] b_q;
      logic [WIDTH-1:0] s_q;
      logic             cy_q;
      logic             sub_q;

      always_ff @(posedge clk) begin
        if (adv) begin
          a_q   <= av;
          b_q   <= bv;
          s_q   <= s_d;
          cy_q  <= t[CHUNK];
          sub_q <= subv;
        end
      end
    end else begin : g_out
      logic [WIDTH-1:0] sum_q;
      logic [WIDTH-1:0] sum_d;
      logic             c_q;
      logic             c_d;
      logic             ovf_q;
      logic             ovf_d;
      logic             zero_q;
      logic             unused_lo;

      assign unused_lo = ^{av, bv};
      assign c_d   = t[CHUNK] ^ subv;
      // b already inverted for sub, so one overflow rule covers both ops
      assign ovf_d = (av[MSB] == bv[MSB]) && (s_d[MSB] != av[MSB]);

`ifdef PIPE_ADDSUB_SAT_EN
      assign sum_d = c_d ? (subv ? '0 : '1) : s_d;
`else
      assign sum_d = s_d;
`endif

      always_ff @(posedge clk) begin
        if (!rst_n) begin
          sum_q  <= '0;
          c_q    <= 1'b0;
          ovf_q  <= 1'b0;
          zero_q <= 1'b0;
        end else if (adv && vv) begin
          sum_q  <= sum_d;
          c_q    <= c_d;
          ovf_q  <= ovf_d;
          zero_q <= (sum_d == '0);
        end
      end
    end
  end

  assign out_valid = g_st[STAGES-1].v_q;
  assign sum       = g_st[STAGES-1].g_out.sum_q;
  assign c         = g_st[STAGES-1].g_out.c_q;
  assign ovf       = g_st[STAGES-1].g_out.ovf_q;
  assign zero      = g_st[STAGES-1].g_out.zero_q;

endmodule

// File: tb/tb_pipe_addsub.sv
// Scoreboard bench for pipe_addsub (WIDTH=8, CHUNK=4).
// Reference model uses plain integer arithmetic.
module tb_pipe_addsub;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       ci = 1'b0;
  logic       sub = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] sum;
  logic       c;
  logic       ovf;
  logic       zero;

  always #5 clk = ~clk;

  pipe_addsub #(.WIDTH(8), .CHUNK(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .ci(ci), .sub(sub),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c(c), .ovf(ovf), .zero(zero)
  );

  typedef struct {
    logic [7:0] s;
    logic       c;
    logic       o;
    logic       z;
    int         acc;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   checks = 0;
  int   passes = 0;
  bit   chk_lat = 1'b0;
  bit   rnd_bp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string n, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)",
                  n, act, exp, cyc);
  endtask

  function automatic exp_t mk(input logic [7:0] s, input logic cc,
                              input logic o, input logic z);
    exp_t e;
    e.s = s; e.c = cc; e.o = o; e.z = z; e.acc = 0;
    return e;
  endfunction

  function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                 input logic ici, input logic isub);
    exp_t e;
    int u;
    int sr;
    int sa;
    int sb;
    sa = int'($signed(ia));
    sb = int'($signed(ib));
    if (isub) begin
      u  = int'(ia) - int'(ib) - int'(ici);
      sr = sa - sb - int'(ici);
      e.c = (u < 0);
    end else begin
      u  = int'(ia) + int'(ib) + int'(ici);
      sr = sa + sb + int'(ici);
      e.c = (u > 255);
    end
    e.s = 8'(u);
    e.o = (sr > 127) || (sr < -128);
`ifdef PIPE_ADDSUB_SAT_EN
    if (e.c) e.s = isub ? 8'h00 : 8'hFF;
`endif
    e.z = (e.s == 8'h00);
    e.acc = 0;
    return e;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      q.delete();
    end else if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        chk("out_unexpected", out_valid, 0);
      end else begin
        e = q.pop_front();
        chk("sum", sum, e.s);
        chk("carry", c, e.c);
        chk("ovf", ovf, e.o);
        chk("zero", zero, e.z);
        if (chk_lat) chk("latency", cyc - e.acc, 2);
      end
    end
  end

  always begin
    @(posedge clk);
    #1;
    if (rnd_bp) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic issue(input logic [7:0] ia, input logic [7:0] ib,
                       input logic ici, input logic isub, input exp_t e);
    int n;
    n = 0;
    a = ia; b = ib; ci = ici; sub = isub; in_valid = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) begin
      chk("in_ready_timeout", in_ready, 1);
    end else begin
      e.acc = cyc;
      q.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic op(input logic [7:0] ia, input logic [7:0] ib,
                    input logic ici, input logic isub);
    issue(ia, ib, ici, isub, model(ia, ib, ici, isub));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("drain_left", q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  logic [7:0] cv[16] = '{8'h00, 8'h01, 8'h02, 8'h0F, 8'h10, 8'h7E,
                         8'h7F, 8'h80, 8'h81, 8'hEF, 8'hF0, 8'hFE,
                         8'hFF, 8'h55, 8'hAA, 8'h3C};

  initial begin
    bit [5:0] pat;
    int k;

    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_sum", sum, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_c", c, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_zero", zero, 0);
    @(posedge clk);
    #1;

    // boundary values with fixed expectations
    chk_lat = 1'b1;
`ifdef PIPE_ADDSUB_SAT_EN
    issue(8'hFF, 8'h01, 0, 0, mk(8'hFF, 1, 0, 0));
    issue(8'h7F, 8'h01, 0, 0, mk(8'h80, 0, 1, 0));
    issue(8'h00, 8'h01, 0, 1, mk(8'h00, 1, 0, 1));
    issue(8'h80, 8'h01, 0, 1, mk(8'h7F, 0, 1, 0));
    issue(8'hF0, 8'h20, 0, 0, mk(8'hFF, 1, 0, 0));
    issue(8'h05, 8'h09, 0, 1, mk(8'h00, 1, 0, 1));
`else
    issue(8'hFF, 8'h01, 0, 0, mk(8'h00, 1, 0, 1));
    issue(8'h7F, 8'h01, 0, 0, mk(8'h80, 0, 1, 0));
    issue(8'h00, 8'h01, 0, 1, mk(8'hFF, 1, 0, 0));
    issue(8'h80, 8'h01, 0, 1, mk(8'h7F, 0, 1, 0));
    issue(8'hF0, 8'h20, 0, 0, mk(8'h10, 1, 0, 0));
    issue(8'h05, 8'h09, 0, 1, mk(8'hFC, 1, 0, 0));
`endif
    drain();

    // corner sweep, back-to-back
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++)
        for (int m = 0; m < 4; m++)
          op(cv[i], cv[j], m[0], m[1]);
    drain();

    // bubble pattern 1,0,1
    fork
      begin
        op(8'h12, 8'h34, 0, 0);
        @(posedge clk);
        #1;
        op(8'h56, 8'h07, 1, 1);
      end
      begin
        @(negedge clk);
        for (int i = 0; i < 6; i++) begin
          pat[i] = out_valid;
          @(negedge clk);
        end
      end
    join
    chk("bubble_pat", pat, 6'b010100);
    drain();

    // backpressure: hold output 3 cycles
    chk_lat = 1'b0;
    out_ready = 1'b0;
    fork
      begin
        op(8'h10, 8'h01, 0, 0);
        op(8'h20, 8'h02, 0, 0);
        op(8'h30, 8'h03, 0, 0);
      end
      begin
        k = 0;
        do begin
          @(negedge clk);
          k++;
        end while (!out_valid && k < 20);
        for (int i = 0; i < 3; i++) begin
          if (i > 0) @(negedge clk);
          chk("stall_valid", out_valid, 1);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_sum", sum, 8'h11);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // random stream with random gaps and backpressure
    rnd_bp = 1'b1;
    for (int i = 0; i < 2000; i++) begin
      op(8'($urandom), 8'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 1)) @(posedge clk);
      #1;
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    out_ready = 1'b1;
    drain();

    // reset mid-stream discards in-flight ops
    op(8'h01, 8'h02, 0, 0);
    op(8'h03, 8'h04, 0, 0);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("flush_out_valid", out_valid, 0);
    end
    chk("flush_sum", sum, 0);
    chk("flush_in_ready", in_ready, 1);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
